// File: rtl/buffer_copy_ctrl_pkg.sv
// Shared definitions for the frame-buffer copy controller: default geometry
// of the 320x240 RGB332 frame and the controller state encoding.
package buffer_copy_ctrl_pkg;

  // Frame-buffer address width; 17 bits covers 76800 pixels.
  localparam int unsigned ADDR_W = 17;

  // Pixel width (RGB332).
  localparam int unsigned DATA_W = 8;

  // Pixels per frame (320x240).
  localparam int unsigned FRAME_PIXELS = 76800;

  // Controller states. Encoding is fixed so it can be probed in the lab.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StIssue  = 2'd1,
    StDrain  = 2'd2,
    StFinish = 2'd3
  } state_e;

endpackage

// File: rtl/buffer_copy_ctrl_rd_valid_pipe.sv
// Read-tracking delay line: carries a valid bit and the issued read address
// alongside the source RAM so each returning pixel knows where it belongs.
// A flush drops every in-flight read (used on abort).
module rd_valid_pipe #(
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              vld_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              vld_o,
  output logic [ADDR_W-1:0] addr_o
);

  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] vld_d;
  logic [ADDR_W-1:0] addr_q [RD_LAT];
  logic [ADDR_W-1:0] addr_d [RD_LAT];

  // Shift one stage per cycle; flush only needs to clear the valid bits.
  always_comb begin
    vld_d     = vld_q;
    addr_d    = addr_q;
    vld_d[0]  = vld_i;
    addr_d[0] = addr_i;
    for (int i = 1; i < int'(RD_LAT); i++) begin
      vld_d[i]  = vld_q[i-1];
      addr_d[i] = addr_q[i-1];
    end
    if (flush_i) begin
      vld_d = '0;
    end
  end

  // Stage registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q  <= '0;
      addr_q <= '{default: '0};
    end else begin
      vld_q  <= vld_d;
      addr_q <= addr_d;
    end
  end

  assign vld_o  = vld_q[RD_LAT-1];
  assign addr_o = addr_q[RD_LAT-1];

endmodule

// File: rtl/buffer_copy_ctrl.sv
// Frame-buffer copy controller: streams every pixel of the working buffer
// into the display buffer at one pixel per cycle. Reads are issued back to
// back; the rd_valid_pipe delay line pairs each returning pixel with its
// address so the write lands one cycle after the data returns.
module buffer_copy_ctrl #(
  parameter int unsigned ADDR_W       = buffer_copy_ctrl_pkg::ADDR_W,
  parameter int unsigned DATA_W       = buffer_copy_ctrl_pkg::DATA_W,
  parameter int unsigned FRAME_PIXELS = buffer_copy_ctrl_pkg::FRAME_PIXELS,
  parameter int unsigned RD_LAT       = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_en,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              err
);

  import buffer_copy_ctrl_pkg::*;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(FRAME_PIXELS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic              err_q, err_d;

  logic              flush;
  logic              issue_vld;
  logic              ret_vld;
  logic [ADDR_W-1:0] ret_addr;

  // The read on rd_addr_q is live for every cycle spent in ISSUE, unless
  // that same cycle is being aborted.
  assign issue_vld = (state_q == StIssue) && !flush;

  rd_valid_pipe #(
    .RD_LAT (RD_LAT),
    .ADDR_W (ADDR_W)
  ) u_rd_valid_pipe (
    .clock   (clock),
    .reset   (reset),
    .flush_i (flush),
    .vld_i   (issue_vld),
    .addr_i  (rd_addr_q),
    .vld_o   (ret_vld),
    .addr_o  (ret_addr)
  );

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    err_d     = 1'b0;
    flush     = 1'b0;

    unique case (state_q)
      StIdle: begin
        // abort beats start; abort alone is a no-op here.
        if (start && !abort) begin
          state_d   = StIssue;
          rd_addr_d = '0;
          busy_d    = 1'b1;
        end
      end
      StIssue: begin
        err_d = start;
        if (abort) begin
          flush     = 1'b1;
          aborted_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = StIdle;
        end else if (rd_addr_q == LastAddr) begin
          // Hold rd_addr at the last pixel; never wrap.
          state_d = StDrain;
        end else begin
          rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
      end
      StDrain: begin
        err_d = start;
        if (abort) begin
          flush     = 1'b1;
          aborted_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = StIdle;
        end else if (ret_vld && (ret_addr == LastAddr)) begin
          // FINISH coincides with the last write appearing on the outputs.
          state_d = StFinish;
        end
      end
      StFinish: begin
        err_d   = start;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase

    // Returning pixel becomes a write next cycle; address/data hold otherwise.
    if (ret_vld && !flush) begin
      wr_en_d   = 1'b1;
      wr_addr_d = ret_addr;
      wr_data_d = rd_data;
    end
  end

  // FSM state and all registered outputs, synchronous reset has priority.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      err_q     <= err_d;
    end
  end

  assign rd_addr = rd_addr_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_en   = wr_en_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign aborted = aborted_q;
  assign err     = err_q;

endmodule

// File: tb/tb_buffer_copy_ctrl.sv
// Bench for buffer_copy_ctrl: a reduced frame (640 px, RD_LAT=2) for the
// copy/abort/err/reset scenarios and a 4-pixel RD_LAT=1 instance for the
// start+abort corner. Expected writes are queued when a copy is started and
// popped as the DUT writes them.
module tb_buffer_copy_ctrl;

  localparam int unsigned AW = 17;
  localparam int unsigned DW = 8;
  localparam int unsigned NA = 640;
  localparam int unsigned LA = 2;
  localparam int unsigned NB = 4;
  localparam int unsigned LB = 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- DUT A ----------------
  logic          start_a = 1'b0;
  logic          abort_a = 1'b0;
  logic [AW-1:0] rd_addr_a, wr_addr_a;
  logic [DW-1:0] rd_data_a, wr_data_a;
  logic          wr_en_a, busy_a, done_a, aborted_a, err_a;

  buffer_copy_ctrl #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .FRAME_PIXELS (NA),
    .RD_LAT       (LA)
  ) u_dut_a (
    .clock   (clock),
    .reset   (reset),
    .start   (start_a),
    .abort   (abort_a),
    .rd_addr (rd_addr_a),
    .rd_data (rd_data_a),
    .wr_addr (wr_addr_a),
    .wr_data (wr_data_a),
    .wr_en   (wr_en_a),
    .busy    (busy_a),
    .done    (done_a),
    .aborted (aborted_a),
    .err     (err_a)
  );

  // Source RAM model: data = addr[7:0], LA cycles of latency.
  logic [DW-1:0] mem_a [LA];
  always @(posedge clock) begin
    mem_a[0] <= rd_addr_a[7:0];
    for (int i = 1; i < int'(LA); i++) mem_a[i] <= mem_a[i-1];
  end
  assign rd_data_a = mem_a[LA-1];

  logic [AW-1:0] qa [$];
  logic [AW-1:0] exp_a;
  logic [AW-1:0] hold_addr_a;
  logic [DW-1:0] hold_data_a;
  logic          rst_prev_a = 1'b1;
  logic          busy_at_done_a;
  int nwr_a, first_wr_a, last_wr_a, done_cnt_a, done_cyc_a, abt_cnt_a, err_cnt_a;

  always @(negedge clock) begin
    if (!reset && !rst_prev_a) begin
      if (wr_en_a) begin
        if (qa.size() == 0) begin
          check_eq("a_unexp_wr", 32'(wr_en_a), 0);
        end else begin
          exp_a = qa.pop_front();
          check_eq("a_wr_addr", 32'(wr_addr_a), 32'(exp_a));
          check_eq("a_wr_data", 32'(wr_data_a), 32'(exp_a[7:0]));
          nwr_a++;
          if (first_wr_a < 0) first_wr_a = cyc;
          last_wr_a = cyc;
        end
      end else begin
        check_eq("a_hold_addr", 32'(wr_addr_a), 32'(hold_addr_a));
        check_eq("a_hold_data", 32'(wr_data_a), 32'(hold_data_a));
      end
      if (done_a) begin
        done_cnt_a++;
        done_cyc_a     = cyc;
        busy_at_done_a = busy_a;
      end
      if (aborted_a) abt_cnt_a++;
      if (err_a) err_cnt_a++;
    end
    hold_addr_a = wr_addr_a;
    hold_data_a = wr_data_a;
    rst_prev_a  = reset;
  end

  task automatic clr_a();
    nwr_a = 0; first_wr_a = -1; last_wr_a = -1; done_cnt_a = 0; done_cyc_a = -1;
    abt_cnt_a = 0; err_cnt_a = 0; busy_at_done_a = 1'b1;
  endtask

  task automatic wait_done_a(input int limit, input string tag);
    int n = 0;
    while (done_cnt_a == 0 && n < limit) begin
      @(negedge clock); #1;
      n++;
    end
    if (done_cnt_a == 0) check_eq({tag, "_done_timeout"}, 32'(done_cnt_a), 1);
  endtask

  task automatic wait_rd_a(input logic [AW-1:0] addr, input int limit, input string tag);
    int n = 0;
    @(negedge clock);
    while (rd_addr_a != addr && n < limit) begin
      @(negedge clock);
      n++;
    end
    if (rd_addr_a != addr) check_eq({tag, "_rd_timeout"}, 32'(rd_addr_a), 32'(addr));
  endtask

  // Full copy; optionally pulse start when rd_addr reaches err_at.
  task automatic run_copy_a(input string tag, input int err_at);
    int t0;
    clr_a();
    for (int i = 0; i < int'(NA); i++) qa.push_back(AW'(i));
    @(posedge clock); #1 start_a = 1'b1;
    @(posedge clock); #1 start_a = 1'b0;
    t0 = cyc;
    @(negedge clock);
    check_eq({tag, "_rd0"}, 32'(rd_addr_a), 0);
    check_eq({tag, "_busy"}, 32'(busy_a), 1);
    if (err_at >= 0) begin
      wait_rd_a(AW'(err_at), int'(NA), tag);
      start_a = 1'b1;
      @(posedge clock); #1 start_a = 1'b0;
    end
    wait_done_a(int'(NA) + 20, tag);
    check_eq({tag, "_first_wr"}, 32'(first_wr_a), 32'(t0 + int'(LA) + 1));
    check_eq({tag, "_done_cyc"}, 32'(done_cyc_a), 32'(t0 + int'(NA) + int'(LA) + 1));
    check_eq({tag, "_last_wr"}, 32'(last_wr_a), 32'(done_cyc_a - 1));
    check_eq({tag, "_nwr"}, 32'(nwr_a), NA);
    check_eq({tag, "_q_left"}, 32'(qa.size()), 0);
    check_eq({tag, "_busy_at_done"}, 32'(busy_at_done_a), 0);
    check_eq({tag, "_err_cnt"}, 32'(err_cnt_a), (err_at >= 0) ? 1 : 0);
    check_eq({tag, "_abt_cnt"}, 32'(abt_cnt_a), 0);
    @(negedge clock);
    check_eq({tag, "_done_pulse"}, 32'(done_a), 0);
    check_eq({tag, "_done_cnt"}, 32'(done_cnt_a), 1);
  endtask

  // ---------------- DUT B ----------------
  logic          start_b = 1'b0;
  logic          abort_b = 1'b0;
  logic [AW-1:0] rd_addr_b, wr_addr_b;
  logic [DW-1:0] rd_data_b, wr_data_b;
  logic          wr_en_b, busy_b, done_b, aborted_b, err_b;

  buffer_copy_ctrl #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .FRAME_PIXELS (NB),
    .RD_LAT       (LB)
  ) u_dut_b (
    .clock   (clock),
    .reset   (reset),
    .start   (start_b),
    .abort   (abort_b),
    .rd_addr (rd_addr_b),
    .rd_data (rd_data_b),
    .wr_addr (wr_addr_b),
    .wr_data (wr_data_b),
    .wr_en   (wr_en_b),
    .busy    (busy_b),
    .done    (done_b),
    .aborted (aborted_b),
    .err     (err_b)
  );

  logic [DW-1:0] mem_b [LB];
  always @(posedge clock) begin
    mem_b[0] <= rd_addr_b[7:0];
    for (int i = 1; i < int'(LB); i++) mem_b[i] <= mem_b[i-1];
  end
  assign rd_data_b = mem_b[LB-1];

  logic [AW-1:0] qb [$];
  logic [AW-1:0] exp_b;
  logic          rst_prev_b = 1'b1;
  int nwr_b = 0, first_wr_b = -1, done_cnt_b = 0, done_cyc_b = -1;
  int busy_cnt_b = 0, abt_cnt_b = 0, err_cnt_b = 0;

  always @(negedge clock) begin
    if (!reset && !rst_prev_b) begin
      if (wr_en_b) begin
        if (qb.size() == 0) begin
          check_eq("b_unexp_wr", 32'(wr_en_b), 0);
        end else begin
          exp_b = qb.pop_front();
          check_eq("b_wr_addr", 32'(wr_addr_b), 32'(exp_b));
          check_eq("b_wr_data", 32'(wr_data_b), 32'(exp_b[7:0]));
          nwr_b++;
          if (first_wr_b < 0) first_wr_b = cyc;
        end
      end
      if (done_b) begin
        done_cnt_b++;
        done_cyc_b = cyc;
      end
      if (busy_b) busy_cnt_b++;
      if (aborted_b) abt_cnt_b++;
      if (err_b) err_cnt_b++;
    end
    rst_prev_b = reset;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0b;
    int n;
    clr_a();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_eq("rst_rd_addr", 32'(rd_addr_a), 0);
    check_eq("rst_wr_addr", 32'(wr_addr_a), 0);
    check_eq("rst_wr_data", 32'(wr_data_a), 0);
    check_eq("rst_wr_en", 32'(wr_en_a), 0);
    check_eq("rst_busy", 32'(busy_a), 0);
    check_eq("rst_done", 32'(done_a), 0);
    check_eq("rst_aborted", 32'(aborted_a), 0);
    check_eq("rst_err", 32'(err_a), 0);

    run_copy_a("full", -1);

    // Abort while rd_addr=100: writes 0..97 land, nothing after.
    clr_a();
    for (int i = 0; i < int'(NA); i++) qa.push_back(AW'(i));
    @(posedge clock); #1 start_a = 1'b1;
    @(posedge clock); #1 start_a = 1'b0;
    wait_rd_a(AW'(100), int'(NA), "abort");
    abort_a = 1'b1;
    @(posedge clock); #1 abort_a = 1'b0;
    qa.delete();
    @(negedge clock);
    check_eq("abort_wr_en", 32'(wr_en_a), 0);
    check_eq("abort_pulse", 32'(aborted_a), 1);
    check_eq("abort_busy", 32'(busy_a), 0);
    repeat (10) @(negedge clock);
    #1;
    check_eq("abort_nwr", 32'(nwr_a), 98);
    check_eq("abort_cnt", 32'(abt_cnt_a), 1);
    check_eq("abort_no_done", 32'(done_cnt_a), 0);

    run_copy_a("err", 500);

    // Reset in DRAIN: writes 0..NA-4 seen before reset, then clean outputs.
    clr_a();
    for (int i = 0; i < int'(NA); i++) qa.push_back(AW'(i));
    @(posedge clock); #1 start_a = 1'b1;
    @(posedge clock); #1 start_a = 1'b0;
    wait_rd_a(AW'(NA - 1), int'(NA) + 10, "rstdrain");
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    qa.delete();
    @(negedge clock);
    check_eq("rstd_rd_addr", 32'(rd_addr_a), 0);
    check_eq("rstd_wr_addr", 32'(wr_addr_a), 0);
    check_eq("rstd_wr_data", 32'(wr_data_a), 0);
    check_eq("rstd_wr_en", 32'(wr_en_a), 0);
    check_eq("rstd_busy", 32'(busy_a), 0);
    check_eq("rstd_done", 32'(done_a), 0);
    check_eq("rstd_aborted", 32'(aborted_a), 0);
    repeat (6) @(negedge clock);
    #1;
    check_eq("rstd_nwr", 32'(nwr_a), NA - 3);
    check_eq("rstd_no_done", 32'(done_cnt_a), 0);
    check_eq("rstd_no_abort", 32'(abt_cnt_a), 0);

    run_copy_a("post_rst", -1);

    // Small instance: start+abort together is ignored, then a plain start.
    busy_cnt_b = 0; nwr_b = 0; abt_cnt_b = 0; err_cnt_b = 0; done_cnt_b = 0;
    @(posedge clock); #1 start_b = 1'b1; abort_b = 1'b1;
    @(posedge clock); #1 start_b = 1'b0; abort_b = 1'b0;
    repeat (4) @(negedge clock);
    #1;
    check_eq("b_sa_busy", 32'(busy_cnt_b), 0);
    check_eq("b_sa_abt", 32'(abt_cnt_b), 0);
    check_eq("b_sa_err", 32'(err_cnt_b), 0);
    check_eq("b_sa_rd_addr", 32'(rd_addr_b), 0);
    for (int i = 0; i < int'(NB); i++) qb.push_back(AW'(i));
    @(posedge clock); #1 start_b = 1'b1;
    @(posedge clock); #1 start_b = 1'b0;
    t0b = cyc;
    n = 0;
    while (done_cnt_b == 0 && n < 30) begin
      @(negedge clock); #1;
      n++;
    end
    if (done_cnt_b == 0) check_eq("b_done_timeout", 32'(done_cnt_b), 1);
    check_eq("b_nwr", 32'(nwr_b), NB);
    check_eq("b_q_left", 32'(qb.size()), 0);
    check_eq("b_first_wr", 32'(first_wr_b), 32'(t0b + int'(LB) + 1));
    check_eq("b_done_cyc", 32'(done_cyc_b), 32'(t0b + int'(NB) + int'(LB) + 1));
    repeat (3) @(negedge clock);
    #1;
    check_eq("b_done_cnt", 32'(done_cnt_b), 1);
    check_eq("b_busy_end", 32'(busy_b), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
